dpi_stream_sequencer: RTL and testbench
=======================================

# dpi_stream_sequencer

Upstream feeder for the per-category regex matcher wrappers. It accepts packet bytes with a flow key and maps the key to a 6-bit stream id through a 64-entry flow table, allocating a new entry on a miss. It then drives the shared matcher bus: load_state, the byte stream and eop, in the order the matchers need to restore, run and save per-stream state. One instance fans out to all NCAT category matchers.

## Interface
- NCAT, 16: number of category matchers; width of the enable vector.
- KEY_W, 32: flow key width.
- DEFAULT_EN, all ones: enable vector written when a new stream is allocated.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  8  packet byte.
- in_vld  in  1  byte valid.
- in_sop  in  1  first byte of packet; in_key is valid on this beat.
- in_eop  in  1  last byte of packet.
- in_key  in  KEY_W  flow key.
- in_rdy  out  1  byte consumed when in_vld & in_rdy.
- cfg_we  in  1  write the per-stream enable table.
- cfg_stream  in  6  stream slot being written.
- cfg_enable  in  NCAT  enable vector for that slot.
- char_in  out  8  byte to the matchers.
- char_in_vld  out  1  char_in is valid.
- load_state  out  1  one-cycle pulse: matchers restore state.
- new_stream_id  out  1  valid with load_state; slot was freshly allocated.
- stream_id  out  6  current slot; held from LOAD through EOP.
- enable  out  NCAT  per-category enable for stream_id; held like stream_id.
- eop  out  1  one-cycle pulse: matchers finalize count and save state.
- drop_cnt  out  16  count of non-sop beats discarded in IDLE; saturates at 0xFFFF.

## Operation
FSM states: IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN0, DRAIN1, EOP.
- **IDLE:**
  - When in_vld & in_sop: register in_key, go to LOOKUP. The beat is not consumed and in_rdy stays 0.
  - When in_vld & !in_sop: in_rdy=1, discard the beat, drop_cnt++.
- **LOOKUP:** Compare the key in parallel against all valid table entries.
  - Hit: slot = matching index, new=0.
  - Miss: slot = lowest invalid index. If the table is full, slot = victim pointer, and the victim pointer increments mod 64. Write the key, set valid, load enable[slot]=DEFAULT_EN, new=1.
  - Latch stream_id=slot.
- **LOAD:** load_state=1, new_stream_id=new, enable=enable_table[slot]. Then go to GAP.
- **GAP:** One idle cycle, so the matchers' state_in_vld lands before the first byte.
- **STREAM:**
  - in_rdy=1.
  - Each accepted beat produces char_in=in_data and char_in_vld=1 on the next cycle (registered).
  - A gap in in_vld produces char_in_vld=0; stalls are unlimited.
  - An accepted beat with in_eop goes to DRAIN0.
  - An in_sop seen mid-packet is treated as data and does not trigger a lookup.
- **DRAIN0, DRAIN1:** Two idle cycles so the accept from the last byte reaches the speculative match flag.
- **EOP:** eop=1 for one cycle, then go to IDLE.
- **Config writes:**
  - cfg_we writes enable_table[cfg_stream] in any state.
  - The enable output is sampled only in LOAD, so a write to the active slot affects the next packet only.
  - If a cfg write and a miss allocation hit the same slot in the same cycle, the allocation wins.
- **Table state:** Entries are never invalidated except by reset.

## Timing
- Reset values: in_rdy=0, char_in=0, char_in_vld=0, load_state=0, new_stream_id=0, stream_id=0, enable=0, eop=0, drop_cnt=0.
- Reset also clears all table valid bits, the victim pointer (to 0), and the enable table (to DEFAULT_EN).
- Reset mid-packet returns to IDLE with all outputs deasserted. The upstream source must restart on a packet boundary.
- Cycle numbering, with the sop beat present at cycle 0 in IDLE:
  - cycle 1: LOOKUP.
  - cycle 2: LOAD (load_state high).
  - cycle 3: GAP.
  - cycle 4: STREAM, in_rdy high.
  - The first char_in_vld appears one cycle after each accept.
  - eop is high exactly 3 cycles after the char_in_vld cycle of the last byte.
- Minimum packet of 1 byte with no stalls: sop at cycle 0, eop at cycle 8, back in IDLE at cycle 9.
- Back-to-back packets: a new sop is examined in cycle 9.

## Structure
- dpi_pkg holds:
  - the FSM state enum;
  - constants NSTREAM=64, SID_W=6, GAP_CYC=1, DRAIN_CYC=2.
- Sub-module dpi_flow_table:
  - 64×KEY_W key regs, valid bits, victim pointer;
  - parallel compare, priority encoders for hit and first-free;
  - one-cycle lookup/allocate.
- The enable table and FSM live in the top.

## Test plan
- **Fresh key:** empty table, key 0xA5A5A5A5, 3 bytes "abc" -> load_state at cycle 2 with new_stream_id=1, stream_id=0, enable=all ones; char_in 'a','b','c' on cycles 5,6,7; eop at cycle 10.
- **Repeat key:** same key again -> stream_id=0, new_stream_id=0. A second distinct key -> stream_id=1, new_stream_id=1.
- **Table full:** 64 distinct keys, then a 65th -> stream_id=0 (victim), new_stream_id=1. A 66th key -> stream_id=1.
- **Stalls and config:**
  - in_vld low for 5 cycles mid-packet -> char_in_vld low for those cycles; eop still 3 cycles after the last char.
  - cfg_we for slot 0 with 0x0003 during STREAM -> enable unchanged until the next packet on slot 0, which shows 0x0003.
- **Stray beats:** 4 non-sop beats in IDLE -> drop_cnt=4, no load_state.
- **Reset:** rst_n low during STREAM -> all outputs 0 next cycle; the next packet with an old key reports new_stream_id=1.

Source files
------------

// File: rtl/dpi_pkg.sv
// Shared types and constants for the DPI stream sequencer and its flow table.
// No logic; latency and backpressure are defined by the modules that import it.
package dpi_pkg;

  localparam int NSTREAM   = 64;
  localparam int SID_W     = 6;
  localparam int GAP_CYC   = 1;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    GAP,
    STREAM,
    DRAIN0,
    DRAIN1,
    EOP
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpi_flow_table.sv
// Flow key -> stream slot map: combinational hit/free search, allocate-on-miss at the clock edge.
// One-cycle lookup; no backpressure, the caller asserts lookup for exactly one cycle per packet.
module dpi_flow_table
  import dpi_pkg::*;
#(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             lookup,
  output logic             hit,
  output logic [SID_W-1:0] slot
);

  logic [KEY_W-1:0]   keys [NSTREAM];
  logic [NSTREAM-1:0] valid;
  logic [NSTREAM-1:0] match;
  logic [SID_W-1:0]   victim;
  logic [SID_W-1:0]   hit_idx;
  logic [SID_W-1:0]   free_idx;
  logic               full;

  always_comb begin
    match = '0;
    for (int i = 0; i < NSTREAM; i++) begin
      match[i] = valid[i] && (keys[i] == key);
    end
  end

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NSTREAM - 1; i >= 0; i--) begin
      if (match[i])  hit_idx  = SID_W'(i);
      if (!valid[i]) free_idx = SID_W'(i);
    end
  end

  assign hit  = |match;
  assign full = &valid;
  assign slot = hit ? hit_idx : (full ? victim : free_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= '0;
      victim <= '0;
    end else if (lookup && !hit) begin
      valid[slot] <= 1'b1;
      if (full) victim <= victim + 1'b1;
    end
  end

  // Key storage needs no reset: an entry is only compared once its valid bit is set.
  always_ff @(posedge clk) begin
    if (lookup && !hit) keys[slot] <= key;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Maps a packet's flow key to a stream slot, then drives load_state / byte stream / eop to the matchers.
// sop->load_state 2 cycles, byte->char_in 1 cycle, last char->eop 3 cycles; in_rdy only in STREAM (or to drop stray beats).
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int              NCAT       = 16,
  parameter int              KEY_W      = 32,
  parameter logic [NCAT-1:0] DEFAULT_EN = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [KEY_W-1:0] in_key,
  output logic             in_rdy,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_stream,
  input  logic [NCAT-1:0]  cfg_enable,
  output logic [7:0]       char_in,
  output logic             char_in_vld,
  output logic             load_state,
  output logic             new_stream_id,
  output logic [5:0]       stream_id,
  output logic [NCAT-1:0]  enable,
  output logic             eop,
  output logic [15:0]      drop_cnt
);

  state_t           state;
  logic [KEY_W-1:0] key_q;
  logic             last_seen;
  logic [NCAT-1:0]  en_tab [NSTREAM];
  logic             ft_hit;
  logic [SID_W-1:0] ft_slot;
  logic             lookup;
  logic             alloc;
  logic             stray;
  logic             accept;

  dpi_flow_table #(
    .KEY_W (KEY_W)
  ) u_flow_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .key    (key_q),
    .lookup (lookup),
    .hit    (ft_hit),
    .slot   (ft_slot)
  );

  assign lookup = (state == LOOKUP);
  assign alloc  = lookup && !ft_hit;
  assign stray  = (state == IDLE) && in_vld && !in_sop;
  assign in_rdy = stray || ((state == STREAM) && !last_seen);
  assign accept = in_vld && in_rdy;

  // last_seen holds STREAM for the cycle the final char is on the bus, so the
  // two drain cycles are counted from that char and eop lands 3 cycles after it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      key_q         <= '0;
      last_seen     <= 1'b0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      enable        <= '0;
      eop           <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      load_state  <= 1'b0;
      eop         <= 1'b0;
      char_in_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (in_vld && in_sop) begin
            key_q <= in_key;
            state <= LOOKUP;
          end else if (stray) begin
            drop_cnt <= sat_inc16(drop_cnt);
          end
        end
        LOOKUP: begin
          stream_id     <= ft_slot;
          new_stream_id <= !ft_hit;
          load_state    <= 1'b1;
          if (!ft_hit)
            enable <= DEFAULT_EN;
          else if (cfg_we && (cfg_stream == ft_slot))
            enable <= cfg_enable;
          else
            enable <= en_tab[ft_slot];
          state <= LOAD;
        end
        LOAD: begin
          new_stream_id <= 1'b0;
          state         <= GAP;
        end
        GAP: state <= STREAM;
        STREAM: begin
          if (last_seen) begin
            last_seen <= 1'b0;
            state     <= DRAIN0;
          end else if (accept) begin
            char_in     <= in_data;
            char_in_vld <= 1'b1;
            if (in_eop) last_seen <= 1'b1;
          end
        end
        DRAIN0: state <= DRAIN1;
        DRAIN1: begin
          eop   <= 1'b1;
          state <= EOP;
        end
        EOP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Allocation is written after the cfg write so it wins on a same-slot collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTREAM; i++) en_tab[i] <= DEFAULT_EN;
    end else begin
      if (cfg_we) en_tab[cfg_stream] <= cfg_enable;
      if (alloc)  en_tab[ft_slot]    <= DEFAULT_EN;
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed + randomized bench for dpi_stream_sequencer against a key/slot table model.
module tb_dpi_stream_sequencer;

  localparam int NCAT  = 16;
  localparam int KEY_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_vld = 1'b0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic [KEY_W-1:0] in_key = '0;
  logic             in_rdy;
  logic             cfg_we = 1'b0;
  logic [5:0]       cfg_stream = '0;
  logic [NCAT-1:0]  cfg_enable = '0;
  logic [7:0]       char_in;
  logic             char_in_vld;
  logic             load_state;
  logic             new_stream_id;
  logic [5:0]       stream_id;
  logic [NCAT-1:0]  enable;
  logic             eop;
  logic [15:0]      drop_cnt;

  always #5 clk = ~clk;

  dpi_stream_sequencer #(
    .NCAT  (NCAT),
    .KEY_W (KEY_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_vld        (in_vld),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_key        (in_key),
    .in_rdy        (in_rdy),
    .cfg_we        (cfg_we),
    .cfg_stream    (cfg_stream),
    .cfg_enable    (cfg_enable),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .stream_id     (stream_id),
    .enable        (enable),
    .eop           (eop),
    .drop_cnt      (drop_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: key table as plain arrays plus a round-robin victim.
  logic [31:0] m_key [64];
  bit          m_val [64];
  int          m_victim;
  logic [15:0] m_en  [64];
  int          m_drop;
  logic [7:0]  pd    [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 64; i++) begin
      m_val[i] = 1'b0;
      m_key[i] = '0;
      m_en[i]  = 16'hFFFF;
    end
    m_victim = 0;
    m_drop   = 0;
  endtask

  function automatic bit model_has(input logic [31:0] k);
    for (int i = 0; i < 64; i++) if (m_val[i] && m_key[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_lookup(input logic [31:0] k, output int sid, output bit nw, output logic [15:0] en);
    sid = -1;
    for (int i = 0; i < 64; i++) if (sid < 0 && m_val[i] && m_key[i] == k) sid = i;
    nw = (sid < 0);
    if (nw) begin
      for (int i = 0; i < 64; i++) if (sid < 0 && !m_val[i]) sid = i;
      if (sid < 0) begin
        sid      = m_victim;
        m_victim = (m_victim + 1) % 64;
      end
      m_key[sid] = k;
      m_val[sid] = 1'b1;
      m_en[sid]  = 16'hFFFF;
    end
    en = m_en[sid];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_rdy"}, in_rdy, 0);
    chk({tag, "_char_in"}, char_in, 0);
    chk({tag, "_char_vld"}, char_in_vld, 0);
    chk({tag, "_load"}, load_state, 0);
    chk({tag, "_new"}, new_stream_id, 0);
    chk({tag, "_sid"}, stream_id, 0);
    chk({tag, "_enable"}, enable, 0);
    chk({tag, "_eop"}, eop, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  // Drives one packet from an IDLE cycle and checks it cycle by cycle; returns in IDLE.
  task automatic run_pkt(input logic [31:0] key, input int len, input int stall_after,
                         input int stall_len, input bit mid_sop, input int cfg_t,
                         input int cfg_slot, input logic [15:0] cfg_val);
    int sid;
    bit nw;
    logic [15:0] en;
    int idx, stall, t;
    bit prev_acc;
    logic [7:0] prev_b;
    model_lookup(key, sid, nw, en);
    in_vld = 1'b1; in_sop = 1'b1; in_key = key; in_data = pd[0]; in_eop = (len == 1);
    #1 chk("idle_sop_rdy", in_rdy, 0);
    tick; chk("lookup_load", load_state, 0);
    tick;
    chk("load_pulse", load_state, 1);
    chk("new_stream_id", new_stream_id, nw);
    chk("stream_id", stream_id, sid);
    chk("enable_load", enable, en);
    tick; chk("gap_load", load_state, 0); chk("gap_rdy", in_rdy, 0);
    tick;
    idx = 0; stall = 0; prev_acc = 1'b0; prev_b = '0; t = 0;
    while (1) begin
      if (prev_acc) begin
        chk("char_vld", char_in_vld, 1);
        chk("char_data", char_in, prev_b);
      end else begin
        chk("char_gap", char_in_vld, 0);
      end
      chk("enable_hold", enable, en);
      chk("stream_id_hold", stream_id, sid);
      chk("no_reload", load_state, 0);
      cfg_we = (t == cfg_t); cfg_stream = cfg_slot[5:0]; cfg_enable = cfg_val;
      if (t == cfg_t) m_en[cfg_slot] = cfg_val;
      if (idx == len) begin
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        break;
      end
      if (t > 100) begin
        chk("stream_timeout", t, 0);
        in_vld = 1'b0;
        break;
      end
      if (idx == stall_after && stall < stall_len) begin
        in_vld = 1'b0;
        stall++;
      end else begin
        in_vld  = 1'b1;
        in_sop  = (idx == 0) || (mid_sop && idx == 1);
        in_data = pd[idx];
        in_eop  = (idx == len - 1);
      end
      #1;
      if (in_vld) chk("stream_rdy", in_rdy, 1);
      prev_acc = in_vld;
      prev_b   = in_data;
      if (in_vld) idx++;
      tick;
      t++;
    end
    tick; cfg_we = 1'b0; chk("eop_early1", eop, 0);
    tick; chk("eop_early2", eop, 0);
    tick; chk("eop_pulse", eop, 1); chk("eop_char_vld", char_in_vld, 0);
    tick; chk("eop_single", eop, 0); chk("idle_load", load_state, 0);
  endtask

  task automatic rand_data(input int len);
    for (int i = 0; i < len; i++) pd[i] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] k;
    int len;
    model_reset();
    repeat (3) tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Fresh key, "abc": chars on cycles 5..7, eop on cycle 10.
    pd[0] = 8'h61; pd[1] = 8'h62; pd[2] = 8'h63;
    run_pkt(32'hA5A5A5A5, 3, -1, 0, 1'b0, -1, 0, 16'h0);

    rand_data(4);
    run_pkt(32'hA5A5A5A5, 4, -1, 0, 1'b0, -1, 0, 16'h0);
    rand_data(3);
    run_pkt(32'h12345678, 3, -1, 0, 1'b1, -1, 0, 16'h0);

    // Stall mid-packet plus a cfg write to the active slot.
    rand_data(5);
    run_pkt(32'hA5A5A5A5, 5, 2, 5, 1'b0, 3, 0, 16'h0003);
    rand_data(1);
    run_pkt(32'hA5A5A5A5, 1, -1, 0, 1'b0, -1, 0, 16'h0);

    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_sop = 1'b0; in_data = 8'($urandom);
      #1 chk("stray_rdy", in_rdy, 1);
      tick;
      m_drop++;
      chk("stray_load", load_state, 0);
    end
    in_vld = 1'b0;
    chk("drop_cnt", drop_cnt, m_drop);

    for (int i = 0; i < 62; i++) begin
      k = $urandom;
      while (model_has(k)) k = $urandom;
      len = $urandom_range(1, 3);
      rand_data(len);
      run_pkt(k, len, -1, 0, 1'b0, -1, 0, 16'h0);
    end
    for (int i = 0; i < 3; i++) begin
      k = $urandom;
      while (model_has(k)) k = $urandom;
      rand_data(2);
      run_pkt(k, 2, -1, 0, 1'b0, -1, 0, 16'h0);
    end
    rand_data(2);
    run_pkt(32'hA5A5A5A5, 2, -1, 0, 1'b0, -1, 0, 16'h0);

    // Reset while streaming.
    pd[0] = 8'h5A; pd[1] = 8'h3C;
    in_vld = 1'b1; in_sop = 1'b1; in_key = 32'h12345678; in_data = pd[0]; in_eop = 1'b0;
    repeat (5) tick;
    chk("rst_pre_char_vld", char_in_vld, 1);
    rst_n = 1'b0; in_vld = 1'b0; in_sop = 1'b0;
    tick;
    check_all_zero("midrst");
    rst_n = 1'b1;
    model_reset();
    rand_data(2);
    run_pkt(32'hA5A5A5A5, 2, -1, 0, 1'b0, -1, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
